// File: rtl/msg_rx_deframer.sv
// Receive-side message deframer: filters on destination UID, strips the header word,
// checks declared length against TLAST and forwards payload through a 2-entry skid buffer.
module msg_rx_deframer #(
    parameter logic [7:0]  LOCAL_UID         = 8'h02,
    parameter logic [15:0] MAX_PAYLOAD_BYTES = 16'd1024
) (
    input  logic        clk_200MHz,
    input  logic        peripheral_aresetn,

    input  logic [31:0] input_r_TDATA,
    input  logic        input_r_TLAST,
    input  logic        input_r_TVALID,
    output logic        input_r_TREADY,

    output logic [31:0] output_r_TDATA,
    output logic        output_r_TLAST,
    output logic [7:0]  output_r_TUSER,
    output logic        output_r_TERR,
    output logic        output_r_TVALID,
    input  logic        output_r_TREADY,

    output logic [15:0] msg_count,
    output logic [15:0] drop_count,
    output logic [15:0] len_err_count
);

    typedef enum logic [1:0] {
        StHdr     = 2'd0,
        StPayload = 2'd1,
        StDrop    = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [7:0]  user;
        logic        err;
    } beat_t;

    state_e      state_q, state_d;
    logic [8:0]  remaining_q, remaining_d;
    logic [7:0]  tx_uid_q, tx_uid_d;
    logic        tready_q, tready_d;
    logic        valid_q, valid_d;
    logic [1:0]  cnt_q, cnt_d;
    beat_t       ent0_q, ent0_d;
    beat_t       ent1_q, ent1_d;
    logic [15:0] msg_count_q, drop_count_q, len_err_count_q;

    logic        in_fire, out_fire;
    logic        push;
    beat_t       push_beat;
    logic        msg_inc, drop_inc, err_inc;

    logic [7:0]  hdr_rx_uid, hdr_tx_uid;
    logic [15:0] hdr_len;
    logic        hdr_legal;
    logic        rem_is_one;

    assign hdr_rx_uid = input_r_TDATA[31:24];
    assign hdr_tx_uid = input_r_TDATA[23:16];
    assign hdr_len    = input_r_TDATA[15:0];
    assign hdr_legal  = (hdr_rx_uid == LOCAL_UID) && (hdr_len != 16'd0) &&
                        (hdr_len[1:0] == 2'b00) && (hdr_len <= MAX_PAYLOAD_BYTES) &&
                        !input_r_TLAST;
    assign rem_is_one = (remaining_q == 9'd1);

    assign in_fire  = input_r_TVALID && tready_q;
    assign out_fire = valid_q && output_r_TREADY;

    // Message framing: decide what the accepted beat does.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tx_uid_d    = tx_uid_q;
        push        = 1'b0;
        push_beat   = '0;
        msg_inc     = 1'b0;
        drop_inc    = 1'b0;
        err_inc     = 1'b0;

        if (in_fire) begin
            unique case (state_q)
                StHdr: begin
                    if (hdr_legal) begin
                        tx_uid_d    = hdr_tx_uid;
                        // Legal length is at most 1024 bytes, so the word count fits 9 bits.
                        remaining_d = hdr_len[10:2];
                        state_d     = StPayload;
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = input_r_TLAST ? StHdr : StDrop;
                    end
                end
                StPayload: begin
                    push           = 1'b1;
                    push_beat.data = input_r_TDATA;
                    push_beat.user = tx_uid_q;
                    if (input_r_TLAST) begin
                        push_beat.last = 1'b1;
                        push_beat.err  = !rem_is_one;
                        msg_inc        = rem_is_one;
                        err_inc        = !rem_is_one;
                        state_d        = StHdr;
                    end else if (rem_is_one) begin
                        // Overlong: close the message here and discard the excess.
                        push_beat.last = 1'b1;
                        push_beat.err  = 1'b1;
                        err_inc        = 1'b1;
                        state_d        = StDrop;
                    end else begin
                        remaining_d = remaining_q - 9'd1;
                    end
                end
                StDrop: begin
                    if (input_r_TLAST) begin
                        state_d = StHdr;
                    end
                end
                default: state_d = StHdr;
            endcase
        end
    end

    // Skid buffer: ent0 is the head and drives the outputs directly.
    always_comb begin
        cnt_d  = cnt_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        case ({push, out_fire})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = push_beat;
                end else begin
                    ent1_d = push_beat;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = push_beat;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_beat;
                end
            end
            default: ;
        endcase
        valid_d  = (cnt_d != 2'd0);
        // Registered ready only drops once both slots are taken.
        tready_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk_200MHz) begin
        if (!peripheral_aresetn) begin
            state_q         <= StHdr;
            remaining_q     <= '0;
            tx_uid_q        <= '0;
            tready_q        <= 1'b0;
            valid_q         <= 1'b0;
            cnt_q           <= '0;
            ent0_q          <= '0;
            ent1_q          <= '0;
            msg_count_q     <= '0;
            drop_count_q    <= '0;
            len_err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tx_uid_q    <= tx_uid_d;
            tready_q    <= tready_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            if (msg_inc) begin
                msg_count_q <= msg_count_q + 16'd1;
            end
            if (drop_inc) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
            if (err_inc) begin
                len_err_count_q <= len_err_count_q + 16'd1;
            end
        end
    end

    assign input_r_TREADY  = tready_q;
    assign output_r_TDATA  = ent0_q.data;
    assign output_r_TLAST  = ent0_q.last;
    assign output_r_TUSER  = ent0_q.user;
    assign output_r_TERR   = ent0_q.err;
    assign output_r_TVALID = valid_q;
    assign msg_count       = msg_count_q;
    assign drop_count      = drop_count_q;
    assign len_err_count   = len_err_count_q;

endmodule
